// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_pkg
//  Brief    : Shared types and helpers for the keypad code lock: FSM state
//             encoding, counter-width helper and digit-slice position helper.
//  Revision : 1.0  initial release
// ============================================================================
package code_lock_pkg;

  // Lock FSM states
  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // LSB position of digit idx in a packed code; digit 0 is the MS digit
  function automatic int digit_lsb(input int idx, input int digits, input int digit_w);
    return (digits - 1 - idx) * digit_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_fsm_if
//  Brief    : Keypad / code / result bundle between the debouncer side
//             (master) and the code lock FSM (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface code_lock_fsm_if
  import code_lock_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 2,
  parameter int MAX_FAILS = 3
);

  localparam int c_fc_w = cnt_width(MAX_FAILS);

  logic [DIGITS*DIGIT_W-1:0] code;
  logic [DIGIT_W-1:0]        key;
  logic                      key_valid;
  logic                      pass;
  logic                      fail;
  logic                      locked;
  logic [c_fc_w-1:0]         fail_cnt;
  logic                      timeout;

  modport master (
    output code, key, key_valid,
    input  pass, fail, locked, fail_cnt, timeout
  );

  modport slave (
    input  code, key, key_valid,
    output pass, fail, locked, fail_cnt, timeout
  );

endinterface
`default_nettype wire

// File: rtl/cl_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cl_cycle_timer
//  Brief    : Loadable down-counter. Counts down while enabled and stops at
//             zero; done is high whenever the count is zero.
//  Revision : 1.0  initial release
// ============================================================================
module cl_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  wire             clk,
  input  wire             clr,
  input  wire             load,
  input  wire [WIDTH-1:0] load_val,
  input  wire             en,
  output logic            done
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over counting; the count saturates at zero
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/code_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_fsm
//  Brief    : Parametrised keypad code lock. Compares a strobed digit sequence
//             against a switch-set code, pulses pass/fail after the full
//             sequence, and locks out input after MAX_FAILS consecutive fails.
//             Optional partial-entry idle timeout: ENTRY_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 2,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int TIMEOUT_CYC = 500
) (
  input  wire             clk,
  input  wire             clr,
  code_lock_fsm_if.slave  bus
);

  localparam int c_idx_w  = cnt_width(DIGITS - 1);
  localparam int c_fc_w   = cnt_width(MAX_FAILS);
  localparam int c_lock_w = cnt_width(LOCKOUT_CYC - 1);

  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(DIGITS - 1);
  localparam logic [c_fc_w-1:0]   c_max_fails = c_fc_w'(MAX_FAILS);
  localparam logic [c_lock_w-1:0] c_lock_load = c_lock_w'(LOCKOUT_CYC - 1);

  state_t              r_state;
  logic [c_idx_w-1:0]  r_idx;
  logic                r_err;
  logic                r_pass;
  logic                r_fail;
  logic                r_locked;
  logic                r_timeout;
  logic [c_fc_w-1:0]   r_fail_cnt;

  logic [DIGIT_W-1:0]  w_digit;
  logic                w_match;
  logic                w_last;
  logic                w_at_max;
  logic                w_take;
  logic                w_lock_load;
  logic                w_lock_en;
  logic                w_lock_done;
  logic                w_idle_expire;

  // Expected digit for the current position, taken from the live code input
  assign w_digit  = bus.code[digit_lsb(int'(r_idx), DIGITS, DIGIT_W) +: DIGIT_W];
  assign w_match  = (bus.key == w_digit);
  assign w_last   = (r_idx == c_last_idx);
  assign w_at_max = (r_fail_cnt == c_max_fails);

  // A key is accepted in ENTRY and in the PASS/FAIL result cycle, except when
  // that FAIL is the one heading into lockout
  assign w_take = bus.key_valid &&
                  ((r_state == ST_ENTRY) || (r_state == ST_PASS) ||
                   ((r_state == ST_FAIL) && !w_at_max));

  assign w_lock_load = (r_state == ST_FAIL) && w_at_max;
  assign w_lock_en   = (r_state == ST_LOCKOUT);

  // Lockout duration: loaded with LOCKOUT_CYC-1 so locked stays high for
  // exactly LOCKOUT_CYC cycles including the zero-count cycle
  cl_cycle_timer #(
    .WIDTH    (c_lock_w)
  ) u_lock_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (w_lock_load),
    .load_val (c_lock_load),
    .en       (w_lock_en),
    .done     (w_lock_done)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int c_idle_w = cnt_width(TIMEOUT_CYC - 1);
  localparam logic [c_idle_w-1:0] c_idle_load = c_idle_w'(TIMEOUT_CYC - 1);

  logic w_idle_en;
  logic w_idle_done;

  // Idle cycles only count while a partial entry is pending
  assign w_idle_en = (r_state == ST_ENTRY) && (r_idx != '0) && !bus.key_valid;

  // Reloaded on every accepted key; expiry is the TIMEOUT_CYC-th idle cycle
  cl_cycle_timer #(
    .WIDTH    (c_idle_w)
  ) u_idle_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (w_take),
    .load_val (c_idle_load),
    .en       (w_idle_en),
    .done     (w_idle_done)
  );

  assign w_idle_expire = w_idle_en && w_idle_done;
`else
  // Feature compiled out: a partial entry waits indefinitely
  assign w_idle_expire = (TIMEOUT_CYC < 0) && 1'b0;
`endif

  // Lock FSM with registered pulse outputs and failure counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ST_ENTRY;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      if (w_take) begin
        if (w_last) begin
          r_idx <= '0;
          r_err <= 1'b0;
          if (!r_err && w_match) begin
            r_state    <= ST_PASS;
            r_pass     <= 1'b1;
            r_fail_cnt <= '0;
          end else begin
            r_state    <= ST_FAIL;
            r_fail     <= 1'b1;
            r_fail_cnt <= r_fail_cnt + 1'b1;
          end
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_err   <= r_err | ~w_match;
          r_state <= ST_ENTRY;
        end
      end else begin
        case (r_state)
          ST_ENTRY: begin
            if (w_idle_expire) begin
              r_idx     <= '0;
              r_err     <= 1'b0;
              r_timeout <= 1'b1;
            end
          end
          ST_PASS: begin
            r_state <= ST_ENTRY;
          end
          ST_FAIL: begin
            if (w_at_max) begin
              r_state  <= ST_LOCKOUT;
              r_locked <= 1'b1;
            end else begin
              r_state <= ST_ENTRY;
            end
          end
          ST_LOCKOUT: begin
            if (w_lock_done) begin
              r_state    <= ST_ENTRY;
              r_locked   <= 1'b0;
              r_fail_cnt <= '0;
            end
          end
          default: begin
            r_state <= ST_ENTRY;
          end
        endcase
      end
    end
  end

  assign bus.pass     = r_pass;
  assign bus.fail     = r_fail;
  assign bus.locked   = r_locked;
  assign bus.fail_cnt = r_fail_cnt;
  assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_code_lock_fsm
//  Brief    : Self-checking bench for code_lock_fsm (DIGITS=4, DIGIT_W=2,
//             MAX_FAILS=3). Result pulses are checked against a scoreboard of
//             expected events pushed when the last digit is driven.
//  Revision : 1.0  initial release
// ============================================================================
module tb_code_lock_fsm;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 2;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_CYC = 1000;
  localparam int TIMEOUT_CYC = 500;

  localparam logic [7:0] c_code = 8'b10_01_11_00;
  localparam logic [1:0] c_ev_pass = 2'd1;
  localparam logic [1:0] c_ev_fail = 2'd2;
  localparam logic [1:0] c_ev_tmo  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  int   m_fcnt   = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;

  code_lock_fsm_if #(
    .DIGITS    (DIGITS),
    .DIGIT_W   (DIGIT_W),
    .MAX_FAILS (MAX_FAILS)
  ) bus ();

  code_lock_fsm #(
    .DIGITS      (DIGITS),
    .DIGIT_W     (DIGIT_W),
    .MAX_FAILS   (MAX_FAILS),
    .LOCKOUT_CYC (LOCKOUT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // One clock cycle: inputs captured at posedge, outputs observed at negedge
  // and matched against the scoreboard head
  task automatic tick();
    logic [2:0] w_obs;
    logic [2:0] w_want;
    ev_t        e;
    @(posedge clk);
    @(negedge clk);
    w_obs = {bus.timeout, bus.fail, bus.pass};
    if (w_obs !== 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got {timeout,fail,pass}=%b want 000 at %0t", w_obs, $time);
      end else begin
        e = sb.pop_front();
        w_want = (e.kind == c_ev_pass) ? 3'b001 : (e.kind == c_ev_fail) ? 3'b010 : 3'b100;
        if (w_obs !== w_want || bus.fail_cnt !== e.cnt) begin
          failures++;
          $display("FAIL result_event got {timeout,fail,pass}=%b fail_cnt=%0d want %b fail_cnt=%0d at %0t",
                   w_obs, bus.fail_cnt, w_want, e.cnt, $time);
        end
      end
    end else if (sb.size() != 0) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL missing_pulse got {timeout,fail,pass}=000 want kind=%0d fail_cnt=%0d at %0t",
               e.kind, e.cnt, $time);
    end
  endtask

  task automatic key_in(input logic [1:0] k);
    bus.key       = k;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.key_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_ev(input logic [1:0] kind);
    ev_t e;
    e.kind = kind;
    e.cnt  = 2'(m_fcnt);
    sb.push_back(e);
  endtask

  // Enter four digits (MS first); model the outcome against the current code
  task automatic send_code(input logic [7:0] seq);
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1) begin
        if (seq == bus.code) begin
          m_fcnt = 0;
          push_ev(c_ev_pass);
        end else begin
          m_fcnt++;
          push_ev(c_ev_fail);
        end
      end
      key_in(seq[(DIGITS - 1 - i) * DIGIT_W +: DIGIT_W]);
    end
  endtask

  task automatic test_reset();
    clr           = 1'b1;
    bus.code      = c_code;
    bus.key       = 2'd0;
    bus.key_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.pass !== 1'b0)     begin failures++; $display("FAIL reset_pass got %b want 0", bus.pass); end
    checks++; if (bus.fail !== 1'b0)     begin failures++; $display("FAIL reset_fail got %b want 0", bus.fail); end
    checks++; if (bus.locked !== 1'b0)   begin failures++; $display("FAIL reset_locked got %b want 0", bus.locked); end
    checks++; if (bus.timeout !== 1'b0)  begin failures++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
    checks++; if (bus.fail_cnt !== 2'd0) begin failures++; $display("FAIL reset_fail_cnt got %0d want 0", bus.fail_cnt); end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    send_code(8'b10_01_11_00);
    tick();
    checks++; if (bus.fail_cnt !== 2'd0) begin failures++; $display("FAIL pass_fail_cnt got %0d want 0", bus.fail_cnt); end
    checks++; if (bus.locked !== 1'b0)   begin failures++; $display("FAIL pass_locked got %b want 0", bus.locked); end
  endtask

  task automatic test_fail();
    send_code(8'b10_00_11_00);
    tick();
    checks++; if (bus.fail_cnt !== 2'd1) begin failures++; $display("FAIL fail_cnt_after_fail got %0d want 1", bus.fail_cnt); end
    send_code(c_code);
  endtask

  task automatic test_fail_fail_pass();
    send_code(8'b00_01_11_00);
    send_code(8'b10_01_11_01);
    tick();
    checks++; if (bus.fail_cnt !== 2'd2) begin failures++; $display("FAIL ffp_two_fails got %0d want 2", bus.fail_cnt); end
    send_code(c_code);
    tick();
    checks++; if (bus.fail_cnt !== 2'd0) begin failures++; $display("FAIL ffp_after_pass got %0d want 0", bus.fail_cnt); end
    send_code(8'b11_11_11_11);
    idle(5);
    checks++; if (bus.fail_cnt !== 2'd1) begin failures++; $display("FAIL ffp_single_fail got %0d want 1", bus.fail_cnt); end
    checks++; if (bus.locked !== 1'b0)   begin failures++; $display("FAIL ffp_no_lockout got %b want 0", bus.locked); end
    send_code(c_code);
  endtask

  task automatic test_back_to_back();
    send_code(c_code);
    send_code(c_code);
    send_code(8'b01_01_11_00);
    send_code(c_code);
    tick();
    checks++; if (bus.fail_cnt !== 2'd0) begin failures++; $display("FAIL b2b_fail_cnt got %0d want 0", bus.fail_cnt); end
  endtask

  task automatic test_code_change();
    key_in(2'd2);
    key_in(2'd1);
    bus.code = 8'b00_00_00_11;
    key_in(2'd0);
    m_fcnt = 0;
    push_ev(c_ev_pass);
    key_in(2'd3);
    bus.code = c_code;
    key_in(2'd2);
    bus.code = 8'b01_01_11_00;
    key_in(2'd1);
    key_in(2'd3);
    push_ev(c_ev_pass);
    key_in(2'd0);
    bus.code = c_code;
    key_in(2'd2);
    key_in(2'd1);
    bus.code = 8'b10_01_00_00;
    key_in(2'd3);
    m_fcnt++;
    push_ev(c_ev_fail);
    key_in(2'd0);
    bus.code = c_code;
    send_code(c_code);
  endtask

  task automatic test_random();
    logic [7:0] seq;
    int         j;
    for (int i = 0; i < 6; i++) begin
      seq      = 8'($urandom);
      bus.code = seq;
      if (i % 2 == 1) begin
        j = int'($urandom_range(0, 3));
        seq[j * DIGIT_W +: DIGIT_W] = seq[j * DIGIT_W +: DIGIT_W] ^ 2'($urandom_range(1, 3));
      end
      send_code(seq);
    end
    bus.code = c_code;
    send_code(c_code);
  endtask

  task automatic test_lockout();
    int n_locked;
    bit saw_cnt_err;
    send_code(8'b00_00_00_00);
    send_code(8'b01_01_01_01);
    send_code(8'b10_01_11_01);
    n_locked    = 0;
    saw_cnt_err = 1'b0;
    for (int i = 0; i < LOCKOUT_CYC + 200; i++) begin
      bus.key       = 2'($urandom_range(0, 3));
      bus.key_valid = 1'($urandom_range(0, 1));
      tick();
      if (bus.locked !== 1'b1) break;
      n_locked++;
      if (bus.fail_cnt !== 2'd3) saw_cnt_err = 1'b1;
    end
    bus.key_valid = 1'b0;
    checks++; if (n_locked != LOCKOUT_CYC) begin failures++; $display("FAIL lockout_length got %0d want %0d", n_locked, LOCKOUT_CYC); end
    checks++; if (saw_cnt_err)             begin failures++; $display("FAIL lockout_fail_cnt got not-3 want 3"); end
    checks++; if (bus.fail_cnt !== 2'd0)   begin failures++; $display("FAIL post_lockout_fail_cnt got %0d want 0", bus.fail_cnt); end
    m_fcnt = 0;
    send_code(c_code);
  endtask

  task automatic test_clr();
    key_in(2'd2);
    key_in(2'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send_code(c_code);
    send_code(8'b11_00_11_00);
    send_code(8'b11_00_11_00);
    send_code(8'b11_00_11_00);
    idle(10);
    checks++; if (bus.locked !== 1'b1)   begin failures++; $display("FAIL clr_pre_locked got %b want 1", bus.locked); end
    clr = 1'b1;
    tick();
    checks++; if (bus.locked !== 1'b0)   begin failures++; $display("FAIL clr_locked got %b want 0", bus.locked); end
    checks++; if (bus.fail_cnt !== 2'd0) begin failures++; $display("FAIL clr_fail_cnt got %0d want 0", bus.fail_cnt); end
    clr    = 1'b0;
    m_fcnt = 0;
    send_code(c_code);
  endtask

  task automatic test_timeout();
`ifdef ENTRY_TIMEOUT_EN
    send_code(8'b00_00_00_00);
    key_in(2'd2);
    key_in(2'd1);
    idle(TIMEOUT_CYC - 1);
    push_ev(c_ev_tmo);
    idle(1);
    checks++; if (bus.fail_cnt !== 2'd1) begin failures++; $display("FAIL timeout_fail_cnt got %0d want 1", bus.fail_cnt); end
    send_code(c_code);
    key_in(2'd2);
    idle(TIMEOUT_CYC - 1);
    key_in(2'd1);
    key_in(2'd3);
    push_ev(c_ev_pass);
    key_in(2'd0);
`else
    key_in(2'd2);
    key_in(2'd1);
    idle(TIMEOUT_CYC + 100);
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL timeout_tied got %b want 0", bus.timeout); end
    key_in(2'd3);
    m_fcnt = 0;
    push_ev(c_ev_pass);
    key_in(2'd0);
`endif
    idle(2);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_fail_fail_pass();
    test_back_to_back();
    test_code_change();
    test_random();
    test_lockout();
    test_clr();
    test_timeout();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
